// File: rtl/servo_pid_mux.sv
// N-channel PID regulator sharing one signed multiplier across channels.
// Each frame runs P, I, D and SUM once per channel, in channel order.
module servo_pid_mux #(
    parameter int unsigned CH   = 4,
    parameter int unsigned W    = 16,
    parameter int unsigned KW   = 18,
    parameter int unsigned FRAC = 8,
    parameter int unsigned CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH*W-1:0]   err,
    input  logic              param_we,
    input  logic [CW-1:0]     param_ch,
    input  logic [2:0]        param_idx,
    input  logic [KW-1:0]     param_data,
    output logic [CH*W-1:0]   u,
    output logic              busy,
    output logic              rdy,
    output logic [CH-1:0]     sat
);
    localparam int unsigned PW  = W + KW + 1;
    localparam int unsigned AW  = W + KW + 1;
    localparam int unsigned AW2 = W + KW + 2;
    localparam int unsigned SW  = W + KW + 3;

    typedef enum logic [2:0] {S_IDLE, S_P, S_I, S_D, S_SUM, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic            busy_q, busy_d, rdy_q, rdy_d;

    logic signed [W-1:0]    e_q     [CH];
    logic signed [W-1:0]    eprev_q [CH];
    logic signed [KW-1:0]   kp_q    [CH];
    logic signed [KW-1:0]   ki_q    [CH];
    logic signed [KW-1:0]   kd_q    [CH];
    logic        [W-2:0]    imax_q  [CH];
    logic        [W-2:0]    umax_q  [CH];
    logic signed [AW-1:0]   acc_q   [CH];
    logic signed [W-1:0]    u_q     [CH];
    logic        [CH-1:0]   en_q, sat_q;
    logic signed [W+KW-1:0] prod_p_q;
    logic signed [PW-1:0]   prod_d_q;

    logic signed [W-1:0]  e_cur, ep_cur;
    logic signed [W:0]    diff;
    logic signed [KW-1:0] mul_a;
    logic signed [W:0]    mul_b;
    logic signed [PW-1:0] prod;
    logic signed [AW2-1:0] acc_sum, ilim;
    logic signed [AW-1:0] acc_d;
    logic signed [SW-1:0] s_full, s_sh, ulim;
    logic signed [W-1:0]  u_d;
    logic                 sat_hit;
    logic                 param_ok;

    // Frame sequencer: four steps per channel, then a one-cycle DONE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_P;
                ch_d    = '0;
            end
            S_P:    state_d = S_I;
            S_I:    state_d = S_D;
            S_D:    state_d = S_SUM;
            S_SUM: begin
                if (ch_q == CW'(CH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_P;
                    ch_d    = ch_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        rdy_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Shared multiplier operand select, integrator clamp and output saturation.
    always_comb begin
        e_cur  = e_q[ch_q];
        ep_cur = eprev_q[ch_q];
        diff   = (W+1)'(e_cur) - (W+1)'(ep_cur);
        mul_a  = '0;
        mul_b  = '0;
        case (state_q)
            S_P: begin mul_a = kp_q[ch_q]; mul_b = (W+1)'(e_cur); end
            S_I: begin mul_a = ki_q[ch_q]; mul_b = (W+1)'(e_cur); end
            S_D: begin mul_a = kd_q[ch_q]; mul_b = diff; end
            default: ;
        endcase
        prod = PW'(mul_a) * PW'(mul_b);

        acc_sum = AW2'(acc_q[ch_q]) + AW2'(prod);
        ilim    = $signed(AW2'({imax_q[ch_q], {FRAC{1'b0}}}));
        if (acc_sum > ilim)       acc_d = AW'(ilim);
        else if (acc_sum < -ilim) acc_d = AW'(-ilim);
        else                      acc_d = AW'(acc_sum);

        s_full  = SW'(prod_p_q) + SW'(acc_q[ch_q]) + SW'(prod_d_q);
        s_sh    = s_full >>> FRAC;
        ulim    = $signed(SW'(umax_q[ch_q]));
        sat_hit = 1'b0;
        if (s_sh > ulim) begin
            u_d     = W'(ulim);
            sat_hit = 1'b1;
        end else if (s_sh < -ulim) begin
            u_d     = W'(-ulim);
            sat_hit = 1'b1;
        end else begin
            u_d = W'(s_sh);
        end

        param_ok = param_we && ({1'b0, param_ch} < (CW+1)'(CH));
    end

    // Datapath and parameter storage; int_rst is written last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p_q <= '0;
            prod_d_q <= '0;
            en_q     <= '1;
            sat_q    <= '0;
            for (int c = 0; c < CH; c++) begin
                e_q[c]     <= '0;
                eprev_q[c] <= '0;
                kp_q[c]    <= '0;
                ki_q[c]    <= '0;
                kd_q[c]    <= '0;
                imax_q[c]  <= '1;
                umax_q[c]  <= '1;
                acc_q[c]   <= '0;
                u_q[c]     <= '0;
            end
        end else begin
            if (state_q == S_IDLE && start) begin
                for (int c = 0; c < CH; c++) e_q[c] <= err[c*W +: W];
            end
            case (state_q)
                S_P: prod_p_q <= (W+KW)'(prod);
                S_I: acc_q[ch_q] <= en_q[ch_q] ? acc_d : '0;
                S_D: begin
                    prod_d_q      <= prod;
                    eprev_q[ch_q] <= en_q[ch_q] ? e_cur : '0;
                end
                S_SUM: begin
                    if (en_q[ch_q]) begin
                        u_q[ch_q] <= u_d;
                        if (sat_hit) sat_q[ch_q] <= 1'b1;
                    end else begin
                        u_q[ch_q] <= '0;
                    end
                end
                default: ;
            endcase
            if (param_ok) begin
                case (param_idx)
                    3'd0: kp_q[param_ch]   <= param_data;
                    3'd1: ki_q[param_ch]   <= param_data;
                    3'd2: kd_q[param_ch]   <= param_data;
                    3'd3: imax_q[param_ch] <= param_data[W-2:0];
                    3'd4: umax_q[param_ch] <= param_data[W-2:0];
                    3'd5: en_q[param_ch]   <= param_data[0];
                    3'd6: begin
                        acc_q[param_ch]   <= '0;
                        eprev_q[param_ch] <= '0;
                        sat_q[param_ch]   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar gc = 0; gc < CH; gc++) begin : g_u
        assign u[gc*W +: W] = u_q[gc];
    end
    assign busy = busy_q;
    assign rdy  = rdy_q;
    assign sat  = sat_q;
endmodule

// File: tb/tb_servo_pid_mux.sv
// Bench for servo_pid_mux: directed test-plan frames followed by random frames,
// each compared against a plain-arithmetic PID model of the channel behaviour.
module tb_servo_pid_mux;
    localparam int CH = 4, W = 16, KW = 18, FRAC = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CH*W-1:0]   err = '0;
    logic              param_we = 1'b0;
    logic [1:0]        param_ch = '0;
    logic [2:0]        param_idx = '0;
    logic [KW-1:0]     param_data = '0;
    logic [CH*W-1:0]   u;
    logic              busy, rdy;
    logic [CH-1:0]     sat;

    servo_pid_mux #(.CH(CH), .W(W), .KW(KW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .err(err),
        .param_we(param_we), .param_ch(param_ch), .param_idx(param_idx),
        .param_data(param_data), .u(u), .busy(busy), .rdy(rdy), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint m_kp[CH], m_ki[CH], m_kd[CH], m_imax[CH], m_umax[CH];
    longint m_acc[CH], m_ep[CH], m_u[CH];
    bit     m_en[CH], m_sat[CH];
    longint f_err[CH];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint u_of(input int c);
        logic signed [W-1:0] v;
        v = u[c*W +: W];
        return longint'(v);
    endfunction

    function automatic longint m_sat_vec();
        longint r = 0;
        for (int c = 0; c < CH; c++) if (m_sat[c]) r = r | (longint'(1) << c);
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0;
            m_imax[c] = 32767; m_umax[c] = 32767;
            m_acc[c] = 0; m_ep[c] = 0; m_u[c] = 0;
            m_en[c] = 1'b1; m_sat[c] = 1'b0;
        end
    endtask

    task automatic model_write(input int ch, input int idx, input logic [KW-1:0] data);
        logic signed [KW-1:0] sd;
        sd = data;
        case (idx)
            0: m_kp[ch] = longint'(sd);
            1: m_ki[ch] = longint'(sd);
            2: m_kd[ch] = longint'(sd);
            3: m_imax[ch] = longint'(data[W-2:0]);
            4: m_umax[ch] = longint'(data[W-2:0]);
            5: m_en[ch] = data[0];
            6: begin m_acc[ch] = 0; m_ep[ch] = 0; m_sat[ch] = 1'b0; end
            default: ;
        endcase
    endtask

    // One frame of the regulator in plain 64-bit arithmetic.
    task automatic model_frame();
        longint e, pp, pd, a, lim, s;
        for (int c = 0; c < CH; c++) begin
            e = f_err[c];
            if (!m_en[c]) begin
                m_u[c] = 0; m_acc[c] = 0; m_ep[c] = 0;
                continue;
            end
            pp = m_kp[c] * e;
            a = m_acc[c] + m_ki[c] * e;
            lim = m_imax[c] * (longint'(1) << FRAC);
            if (a > lim) a = lim;
            if (a < -lim) a = -lim;
            m_acc[c] = a;
            pd = m_kd[c] * (e - m_ep[c]);
            m_ep[c] = e;
            s = (pp + a + pd) >>> FRAC;
            if (s > m_umax[c]) begin s = m_umax[c]; m_sat[c] = 1'b1; end
            if (s < -m_umax[c]) begin s = -m_umax[c]; m_sat[c] = 1'b1; end
            m_u[c] = s;
        end
    endtask

    task automatic write_param(input int ch, input int idx, input logic [KW-1:0] data);
        @(negedge clk);
        param_we = 1'b1; param_ch = 2'(ch); param_idx = 3'(idx); param_data = data;
        model_write(ch, idx, data);
        @(negedge clk);
        param_we = 1'b0;
    endtask

    task automatic set_err(input longint e0, input longint e1, input longint e2, input longint e3);
        f_err[0] = e0; f_err[1] = e1; f_err[2] = e2; f_err[3] = e3;
    endtask

    task automatic run_frame(input bit pulse_mid, input bit rst_mid);
        int busy_cnt = 0, rdy_cnt = 0, rdy_at = -1;
        bit aborted = 1'b0;
        longint exp_u[CH];
        @(negedge clk);
        for (int c = 0; c < CH; c++) err[c*W +: W] = W'(f_err[c]);
        start = 1'b1;
        model_frame();
        for (int c = 0; c < CH; c++) exp_u[c] = m_u[c];
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rdy) begin rdy_cnt++; rdy_at = j; end
            if (rst_mid && j == 9) begin
                check("rst_busy", longint'(busy), 0);
                check("rst_rdy", longint'(rdy), 0);
                check("rst_sat", longint'(sat), 0);
                for (int c = 0; c < CH; c++) check($sformatf("rst_u%0d", c), u_of(c), 0);
                rst = 1'b0;
                model_reset();
                aborted = 1'b1;
                rdy_cnt = 0;
            end
            for (int c = 0; c < CH; c++)
                if (!aborted && j == 4*c + 5) check($sformatf("u%0d_at_t+%0d", c, j), u_of(c), exp_u[c]);
            if (j == 1) start = 1'b0;
            if (j == 2) err = {$urandom(), $urandom()};
            if (pulse_mid && j == 5) start = 1'b1;
            if (pulse_mid && j == 6) start = 1'b0;
            if (rst_mid && j == 8) rst = 1'b1;
        end
        if (aborted) begin
            check("abort_no_rdy", rdy_cnt, 0);
        end else begin
            check("busy_cycles", busy_cnt, 4*CH + 1);
            check("rdy_count", rdy_cnt, 1);
            check("rdy_cycle", rdy_at, 4*CH + 1);
            check("sat", longint'(sat), m_sat_vec());
            for (int c = 0; c < CH; c++) check($sformatf("u%0d_end", c), u_of(c), m_u[c]);
        end
    endtask

    initial begin
        int exp_i[4];
        int exp_d[3];
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_rdy", longint'(rdy), 0);
        check("reset_sat", longint'(sat), 0);
        check("reset_u", longint'(u == '0), 1);

        // All gains zero.
        set_err(1000, 1000, 1000, 1000);
        run_frame(1'b0, 1'b0);
        check("zero_gain_u", longint'(u == '0), 1);

        // Proportional only.
        write_param(1, 0, 18'd512);
        set_err(0, 100, 0, 0);
        run_frame(1'b0, 1'b0);
        check("kp_u1", u_of(1), 200);

        // Integrator with clamp, then integrator reset.
        write_param(2, 1, 18'd256);
        write_param(2, 3, 18'd250);
        exp_i = '{100, 200, 250, 250};
        for (int k = 0; k < 4; k++) begin
            set_err(0, 0, 100, 0);
            run_frame(1'b0, 1'b0);
            check($sformatf("ki_u2_f%0d", k), u_of(2), exp_i[k]);
        end
        write_param(2, 6, 18'd0);
        run_frame(1'b0, 1'b0);
        check("int_rst_u2", u_of(2), 100);

        // Derivative.
        write_param(0, 2, 18'd256);
        exp_d = '{0, 50, 0};
        set_err(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            f_err[0] = (k == 0) ? 0 : 50;
            run_frame(1'b0, 1'b0);
            check($sformatf("kd_u0_f%0d", k), u_of(0), exp_d[k]);
        end

        // Output saturation with sticky flag.
        write_param(3, 0, 18'd2560);
        write_param(3, 4, 18'd1000);
        set_err(50, 0, 0, -500);
        run_frame(1'b0, 1'b0);
        check("sat_u3", u_of(3), -1000);
        check("sat_flag3", longint'(sat[3]), 1);
        set_err(50, 0, 0, 0);
        run_frame(1'b0, 1'b0);
        check("sat_u3_zero", u_of(3), 0);
        check("sat_flag3_sticky", longint'(sat[3]), 1);

        // Start while busy, disabled channel, reset mid-frame.
        run_frame(1'b1, 1'b0);
        write_param(1, 5, 18'd0);
        set_err(0, 100, 0, 0);
        run_frame(1'b0, 1'b0);
        check("disabled_u1", u_of(1), 0);
        run_frame(1'b0, 1'b1);

        // Random parameters and errors.
        for (int k = 0; k < 30; k++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                int idx;
                logic [KW-1:0] d;
                idx = int'($urandom_range(0, 7));
                d = KW'($urandom());
                if (idx <= 2 && $urandom_range(0, 1) == 1) d = KW'($signed(10'($urandom())));
                if (idx == 5 && $urandom_range(0, 3) != 0) d = KW'(1);
                write_param(int'($urandom_range(0, CH-1)), idx, d);
            end
            for (int c = 0; c < CH; c++) f_err[c] = longint'($signed(W'($urandom())));
            run_frame(($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
